// File: rtl/ll_multi_fifo.sv
// ll_multi_fifo: several logical FIFOs that share one storage array.
// Entries are kept on singly linked lists: one list per queue plus a
// free list. Pushes allocate from the free-list head; pops release the
// popped entry to the free-list tail. Reads are show-ahead.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push         enqueue request, push_sel = target queue, data_in = word
//   pop          dequeue request, pop_sel = source queue
//   data_out     head word of queue pop_sel (combinational)
//   empty/full   per-queue status vectors
//   counts       packed per-queue occupancy, queue i at [i*CNT_WIDTH +: CNT_WIDTH]
//   free_count   entries on the free list
//   push_err     one-cycle pulse after a rejected push
//   pop_err      one-cycle pulse after a rejected pop
module ll_multi_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int NUM_FIFOS    = 2,
  parameter int MAX_PER_FIFO = DEPTH,
  localparam int PTR_WIDTH   = $clog2(DEPTH),
  localparam int SEL_WIDTH   = $clog2(NUM_FIFOS),
  localparam int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [SEL_WIDTH-1:0]           push_sel,
  input  logic [WIDTH-1:0]               data_in,
  input  logic                           pop,
  input  logic [SEL_WIDTH-1:0]           pop_sel,
  output logic [WIDTH-1:0]               data_out,
  output logic [NUM_FIFOS-1:0]           empty,
  output logic [NUM_FIFOS-1:0]           full,
  output logic [NUM_FIFOS*CNT_WIDTH-1:0] counts,
  output logic [CNT_WIDTH-1:0]           free_count,
  output logic                           push_err,
  output logic                           pop_err
);

  localparam logic [SEL_WIDTH:0]   NQ      = (SEL_WIDTH + 1)'(NUM_FIFOS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_PER_FIFO);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     mem    [DEPTH];
  logic [PTR_WIDTH-1:0] nxt    [DEPTH];
  logic [PTR_WIDTH-1:0] q_head [NUM_FIFOS];
  logic [PTR_WIDTH-1:0] q_tail [NUM_FIFOS];
  logic [CNT_WIDTH-1:0] q_cnt  [NUM_FIFOS];
  logic [PTR_WIDTH-1:0] f_head, f_tail;
  logic [CNT_WIDTH-1:0] f_cnt;

  logic                 push_sel_ok, pop_sel_ok;
  logic [SEL_WIDTH-1:0] ps, qs;
  logic                 push_ok, pop_ok, same_q;
  logic [PTR_WIDTH-1:0] alloc, rel;

  always_comb begin
    push_sel_ok = {1'b0, push_sel} < NQ;
    pop_sel_ok  = {1'b0, pop_sel} < NQ;
    // Clamp selects so array reads never go out of range.
    ps = push_sel_ok ? push_sel : '0;
    qs = pop_sel_ok  ? pop_sel  : '0;
    counts = '0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      empty[i] = (q_cnt[i] == '0);
      full[i]  = (q_cnt[i] == CNT_MAX) | (f_cnt == '0);
      counts[i*CNT_WIDTH +: CNT_WIDTH] = q_cnt[i];
    end
    free_count = f_cnt;
    alloc      = f_head;
    rel        = q_head[qs];
    data_out   = mem[q_head[qs]];
  end

  assign push_ok = push & push_sel_ok & ~full[ps];
  assign pop_ok  = pop  & pop_sel_ok  & ~empty[qs];
  assign same_q  = push_ok & pop_ok & (ps == qs);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++)
        nxt[k] <= (k == DEPTH - 1) ? '0 : PTR_WIDTH'(k + 1);
      for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
        q_head[i] <= '0;
        q_tail[i] <= '0;
        q_cnt[i]  <= '0;
      end
      f_head   <= '0;
      f_tail   <= PTR_WIDTH'(DEPTH - 1);
      f_cnt    <= CNT_WIDTH'(DEPTH);
      push_err <= 1'b0;
      pop_err  <= 1'b0;
    end else begin
      push_err <= push & ~push_ok;
      pop_err  <= pop & ~pop_ok;

      if (push_ok) begin
        f_head <= nxt[f_head];
        if (q_cnt[ps] == '0) q_head[ps] <= alloc;
        else                 nxt[q_tail[ps]] <= alloc;
        q_tail[ps] <= alloc;
      end

      if (pop_ok) begin
        // With one entry and a same-queue push, the old head's nxt link is
        // being written this cycle, so take the allocated entry directly.
        q_head[qs] <= (same_q && q_cnt[qs] == CNT_ONE) ? alloc : nxt[rel];
        // Free list becomes empty after this cycle's allocation (or already
        // is): the released entry is the whole list. Overrides f_head above.
        if (f_cnt == '0 || (push_ok && f_cnt == CNT_ONE)) begin
          f_head <= rel;
          f_tail <= rel;
        end else begin
          nxt[f_tail] <= rel;
          f_tail      <= rel;
        end
      end

      case ({push_ok, pop_ok})
        2'b10:   f_cnt <= f_cnt - CNT_ONE;
        2'b01:   f_cnt <= f_cnt + CNT_ONE;
        default: f_cnt <= f_cnt;
      endcase

      for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
        if (push_ok && ps == SEL_WIDTH'(i) && !(pop_ok && qs == SEL_WIDTH'(i)))
          q_cnt[i] <= q_cnt[i] + CNT_ONE;
        else if (pop_ok && qs == SEL_WIDTH'(i) && !(push_ok && ps == SEL_WIDTH'(i)))
          q_cnt[i] <= q_cnt[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[alloc] <= data_in;
  end

endmodule

// File: doc/ll_multi_fifo.md
LL_MULTI_FIFO -- requirements
Module: ll_multi_fifo

Interface
REQ-001 Parameter WIDTH, 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, 4, shared storage entries (>=2).
REQ-003 Parameter NUM_FIFOS, 2, logical queues sharing storage (>=2).
REQ-004 Parameter MAX_PER_FIFO, DEPTH, per-queue occupancy cap (1..DEPTH).
REQ-005 Derived widths SHALL be: PTR_WIDTH=$clog2(DEPTH), SEL_WIDTH=$clog2(NUM_FIFOS), CNT_WIDTH=$clog2(DEPTH+1).
REQ-006 clk  input  1  sole clock; all state updates on posedge clk.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 push  input  1  enqueue request.
REQ-009 push_sel  input  SEL_WIDTH  target queue of push.
REQ-010 data_in  input  WIDTH  enqueue data.
REQ-011 pop  input  1  dequeue request.
REQ-012 pop_sel  input  SEL_WIDTH  source queue of pop.
REQ-013 data_out  output  WIDTH  head word of queue pop_sel, show-ahead.
REQ-014 empty  output  NUM_FIFOS  bit i high when queue i holds 0 entries.
REQ-015 full  output  NUM_FIFOS  bit i high when queue i cannot accept a push.
REQ-016 counts  output  NUM_FIFOS*CNT_WIDTH  queue i occupancy in bits [i*CNT_WIDTH +: CNT_WIDTH].
REQ-017 free_count  output  CNT_WIDTH  entries on the free list.
REQ-018 push_err  output  1  one-cycle pulse: push rejected in previous cycle.
REQ-019 pop_err  output  1  one-cycle pulse: pop rejected in previous cycle.

Function
REQ-020 Storage SHALL be one DEPTH x WIDTH data array plus a DEPTH x PTR_WIDTH next-pointer array; each queue keeps head, tail, count; the free list is a linked list with its own head, tail, count.
REQ-021 full[i] SHALL be (counts[i]==MAX_PER_FIFO) | (free_count==0), evaluated from current-cycle state only.
REQ-022 A push SHALL be accepted iff push & ~full[push_sel]; accepted push takes the free-list head entry, writes data_in, appends it to tail of queue push_sel, count+1, free_count-1.
REQ-023 A pop SHALL be accepted iff pop & ~empty[pop_sel]; accepted pop unlinks queue head, appends that entry to free-list tail, count-1, free_count+1.
REQ-024 data_out SHALL be combinational data[head[pop_sel]]; value when empty[pop_sel] is don't-care; pop latency zero (word valid in the accepting cycle).
REQ-025 Entry freed by a pop SHALL NOT be reallocated in the same cycle; a push in a cycle with free_count==0 is rejected even if a pop is accepted.
REQ-026 Simultaneous accepted push and pop to the same queue SHALL both take effect; count unchanged; when count was 1, new head = pushed entry.
REQ-027 Push and pop on the same queue with count 0: push accepted, pop rejected.
REQ-028 Rejected push/pop SHALL leave all state unchanged for that operation; push_err/pop_err asserted exactly the next cycle, for one cycle per rejection.
REQ-029 Free list SHALL be FIFO-ordered: allocation from head, release to tail.
REQ-030 Invariant: free_count + sum(counts) == DEPTH every cycle; no entry on two lists.
REQ-031 Pointer arithmetic SHALL stay within 0..DEPTH-1 for non-power-of-2 DEPTH; pointers never computed by increment.
REQ-032 Invalid pop_sel/push_sel (>= NUM_FIFOS) SHALL be treated as rejected requests.

Reset
REQ-033 On rst high at posedge clk, regardless of in-flight requests: free list = entries 0,1,..,DEPTH-1 in order (next[k]=k+1), free_count=DEPTH, all counts 0, empty all ones, full all zeros, push_err=pop_err=0.
REQ-034 Push/pop in a reset cycle SHALL be ignored and SHALL NOT raise error pulses.
REQ-035 Data array contents SHALL not require reset.

Verification (WIDTH=8, DEPTH=4, NUM_FIFOS=2, MAX_PER_FIFO=3)
REQ-036 Reset, push 0xA1,0xA2 to q0, 0xB1 to q1 -> counts 2/1, free_count 1; pop q0 returns 0xA1 then 0xA2; entries used 0,1,2.
REQ-037 Push 3 to q0 then push q0 -> full[0]=1 with free_count 1, 4th push rejected, push_err pulses next cycle, counts[0] stays 3.
REQ-038 Fill q0=3, q1=1 (free_count 0); same cycle pop q0 and push q1 -> pop accepted, push rejected, push_err=1, free_count 1.
REQ-039 q1 count 1 holding 0x11; push 0x22 and pop q1 same cycle -> data_out 0x11 that cycle, then count 1, data_out 0x22.
REQ-040 Pop empty q1 -> pop_err pulses one cycle, state unchanged; assert rst mid-sequence -> REQ-033 values next cycle.
REQ-041 Random push/pop 10k cycles vs NUM_FIFOS reference queues -> data order matches, REQ-030 invariant holds every cycle.
